// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: WIDTH bits split into STAGES chunks,
// one chunk per stage, carry registered between stages, flags on the assembled result.
module pipelined_cla_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    // WIDTH must be a multiple of STAGES.
    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // CW-bit chunk add built from 4-bit groups: each carry inside a group is a
    // lookahead term of the group's carry-in, and the group carry-out feeds the next group.
    function automatic logic [CW:0] cla_chunk(input logic [CW-1:0] x, input logic [CW-1:0] y,
                                              input logic ci);
        logic [CW-1:0] g;
        logic [CW-1:0] p;
        logic [CW:0]   c;
        logic          gg;
        logic          gp;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < CW; i += 4) begin
            gg = 1'b0;
            gp = 1'b1;
            for (int j = 0; j < 4; j++) begin
                if (i + j < CW) begin
                    gg         = g[i+j] | (p[i+j] & gg);
                    gp         = gp & p[i+j];
                    c[i+j+1]   = gg | (gp & c[i]);
                end
            end
        end
        return {c[CW], p ^ c[CW-1:0]};
    endfunction

    // Handshake: a beat moves on a rising edge when in_valid && in_ready (input side)
    // or out_valid && out_ready (output side); adv freezes every stage together.
    logic adv;

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] c_in;
    logic [STAGES-1:0] c_nx;
    logic [WIDTH-1:0]  a_q  [STAGES];
    logic [WIDTH-1:0]  b_q  [STAGES];
    logic [WIDTH-1:0]  s_q  [STAGES];
    logic [WIDTH-1:0]  a_in [STAGES];
    logic [WIDTH-1:0]  b_in [STAGES];
    logic [WIDTH-1:0]  s_in [STAGES];
    logic [WIDTH-1:0]  s_nx [STAGES];
    logic              ovf_nx;
    logic              ovf_q;
    logic              zero_q;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign overflow  = ovf_q;
    assign zero      = zero_q;

    always_comb begin
        // Stage 0 sees the prepared operands; later stages see the skewed copies
        // and the partial sum assembled so far.
        a_in[0] = a;
        b_in[0] = sub ? ~b : b;
        c_in[0] = sub | cin;
        s_in[0] = '0;
        v_in[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            c_in[k] = c_q[k-1];
            s_in[k] = s_q[k-1];
            v_in[k] = v_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            s_nx[k] = s_in[k];
            {c_nx[k], s_nx[k][k*CW +: CW]} =
                cla_chunk(a_in[k][k*CW +: CW], b_in[k][k*CW +: CW], c_in[k]);
        end
        // Carry into the MSB recovered from the MSB's own sum bit.
        ovf_nx = a_in[LAST][WIDTH-1] ^ b_in[LAST][WIDTH-1] ^ s_nx[LAST][WIDTH-1] ^ c_nx[LAST];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q       <= '0;
            s_q[LAST] <= '0;
            c_q[LAST] <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
        end else if (adv) begin
            v_q <= v_in;
            for (int k = 0; k < LAST; k++) begin
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                s_q[k] <= s_nx[k];
                c_q[k] <= c_nx[k];
            end
            // Output registers only move for a real beat so bubbles leave them intact.
            if (v_in[LAST]) begin
                s_q[LAST] <= s_nx[LAST];
                c_q[LAST] <= c_nx[LAST];
                ovf_q     <= ovf_nx;
                zero_q    <= (s_nx[LAST] == '0);
            end
        end
    end
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: four parameter sets driven by one stimulus stream,
// each with its own expected queue fed by an arithmetic reference model.
module tb_pipelined_cla_addsub;
    localparam int NCFG = 4;

    function automatic int cfg_w(input int i);
        case (i)
            0: return 32;
            1: return 32;
            2: return 64;
            default: return 16;
        endcase
    endfunction

    function automatic int cfg_s(input int i);
        case (i)
            0: return 4;
            1: return 1;
            2: return 8;
            default: return 2;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        done = 1'b0;
    logic        rdy  [NCFG];
    logic        ovld [NCFG];
    logic [71:0] obs  [NCFG];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] pk(input logic o, input logic z, input logic c,
                                       input logic [63:0] r);
        return {5'd0, o, z, c, r};
    endfunction

    // Reference: plain unsigned arithmetic for sum/carry, signed range test for overflow.
    function automatic logic [71:0] model(input int w, input logic [63:0] x, input logic [63:0] y,
                                          input logic s, input logic ci);
        logic [64:0]        m;
        logic [64:0]        xm;
        logic [64:0]        ym;
        logic [64:0]        res;
        logic signed [65:0] sx;
        logic signed [65:0] sy;
        logic signed [65:0] val;
        logic signed [65:0] lim;
        logic               co;
        logic               ov;
        m  = (65'd1 << w) - 65'd1;
        xm = {1'b0, x} & m;
        ym = {1'b0, y} & m;
        if (s) begin
            res = xm - ym;
            co  = (xm >= ym);
        end else begin
            res = xm + ym + {64'd0, ci};
            co  = res[w];
        end
        res = res & m;
        sx  = $signed(66'({1'b0, xm} << (66 - w))) >>> (66 - w);
        sy  = $signed(66'({1'b0, ym} << (66 - w))) >>> (66 - w);
        val = s ? (sx - sy) : (sx + sy + $signed({65'd0, ci}));
        lim = 66'sd1 <<< (w - 1);
        ov  = (val >= lim) || (val < -lim);
        return pk(ov, (res == 65'd0), co, res[63:0]);
    endfunction

    // ---------------- DUTs and scoreboards ----------------
    for (genvar i = 0; i < NCFG; i++) begin : g_cfg
        localparam int W = cfg_w(i);
        localparam int S = cfg_s(i);
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
        logic         ir;
        logic         ov;
        logic [71:0]  exp_q [$];
        int           cyc_q [$];
        int           stl_q [$];
        int           stalls = 0;
        logic [71:0]  e;
        int           ec;
        int           es;
        logic         rep = 1'b0;

        pipelined_cla_addsub #(.WIDTH(W), .STAGES(S)) dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir),
            .a(a[W-1:0]), .b(b[W-1:0]), .sub(sub), .cin(cin),
            .out_valid(ov), .out_ready(out_ready), .sum(sum), .cout(cout),
            .overflow(ovf), .zero(zero)
        );

        assign rdy[i]  = ir;
        assign ovld[i] = ov;
        assign obs[i]  = {5'd0, ovf, zero, cout, 64'(sum)};

        always @(negedge clk) begin
            if (rst) begin
                exp_q.delete();
                cyc_q.delete();
                stl_q.delete();
            end else begin
                check($sformatf("cfg%0d_in_ready", i), {71'd0, ir}, {71'd0, (!ov || out_ready)});
                if (ov && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("cfg%0d_spurious", i), {71'd0, ov}, 72'd0);
                    end else begin
                        e  = exp_q.pop_front();
                        ec = cyc_q.pop_front();
                        es = stl_q.pop_front();
                        check($sformatf("cfg%0d_result", i), obs[i], e);
                        check($sformatf("cfg%0d_latency", i), 72'(cyc - ec), 72'(S + stalls - es));
                    end
                end else if (ov && exp_q.size() > 0) begin
                    check($sformatf("cfg%0d_frozen", i), obs[i], exp_q[0]);
                end
                if (ov && !out_ready) stalls++;
                if (in_valid && ir) begin
                    exp_q.push_back(model(W, a, b, sub, cin));
                    cyc_q.push_back(cyc);
                    stl_q.push_back(stalls);
                end
                if (done && !rep) begin
                    check($sformatf("cfg%0d_pending", i), 72'(exp_q.size()), 72'd0);
                    rep = 1'b1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        a   = {$urandom, $urandom};
        b   = {$urandom, $urandom};
        sub = 1'($urandom_range(0, 1));
        cin = 1'($urandom_range(0, 1));
    endtask

    task automatic single(input logic [63:0] x, input logic [63:0] y, input logic s,
                          input logic c, input logic [71:0] exp, input string tag);
        int n;
        n = 0;
        a = x;
        b = y;
        sub = s;
        cin = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        while (!ovld[0] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_valid"}, {71'd0, ovld[0]}, 72'd1);
        check(tag, obs[0], exp);
        drain(10);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NCFG; i++) begin
            check($sformatf("cfg%0d_reset_out", i), obs[i], 72'd0);
            check($sformatf("cfg%0d_reset_hs", i), {70'd0, ovld[i], rdy[i]}, 72'd1);
        end
        @(posedge clk);
        #1;

        single(64'h7FFFFFFF, 64'd1, 1'b0, 1'b0, pk(1'b1, 1'b0, 1'b0, 64'h80000000), "msb_overflow");
        single(64'hFFFFFFFF, 64'd1, 1'b0, 1'b0, pk(1'b0, 1'b1, 1'b1, 64'd0), "full_ripple");
        single(64'd5, 64'd7, 1'b1, 1'b0, pk(1'b0, 1'b0, 1'b0, 64'hFFFFFFFE), "sub_borrow");
        single(64'h80000000, 64'd1, 1'b1, 1'b0, pk(1'b1, 1'b0, 1'b1, 64'h7FFFFFFF), "sub_overflow");
        single(64'h12345678, 64'h12345678, 1'b1, 1'b1, pk(1'b0, 1'b1, 1'b1, 64'd0), "sub_zero");
        single(64'h7FFFFFFF, 64'd0, 1'b0, 1'b1, pk(1'b1, 1'b0, 1'b0, 64'h80000000), "cin_overflow");

        // back-to-back burst
        for (int k = 0; k < 8; k++) begin
            rand_ops();
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain(12);

        // stream with a three-cycle downstream stall
        for (int k = 0; k < 12; k++) begin
            rand_ops();
            in_valid  = 1'b1;
            out_ready = (k < 5 || k > 7);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain(12);

        // reset with beats in flight
        for (int k = 0; k < 3; k++) begin
            rand_ops();
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NCFG; i++) begin
            check($sformatf("cfg%0d_flush_valid", i), {71'd0, ovld[i]}, 72'd0);
            check($sformatf("cfg%0d_flush_out", i), obs[i], 72'd0);
        end
        @(posedge clk);
        #1;
        rand_ops();
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain(12);

        // random sweep with random backpressure
        repeat (1100) begin
            rand_ops();
            in_valid  = ($urandom_range(0, 9) < 9);
            out_ready = ($urandom_range(0, 9) < 8);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain(20);
        done = 1'b1;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
